// File: rtl/uart_if.sv
// CPU-side bus bundle for the UART peripheral: decoded select, commit strobe,
// register offset, write/read data and the interrupt request.
interface uart_if;
  logic       cs;
  logic       cpu_strobe;
  logic       rw;
  logic       addr;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       irq;

  modport master (
    output cs, cpu_strobe, rw, addr, data_in,
    input  data_out, irq
  );

  modport slave (
    input  cs, cpu_strobe, rw, addr, data_in,
    output data_out, irq
  );
endinterface

// File: rtl/uart.sv
// 8N1 memory-mapped UART: DATA at offset 0, STATUS at offset 1, level irq on
// received data. TX and RX each run a DIV-cycle bit timer.
module uart #(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115200
) (
  input  logic    clk,
  input  logic    rst,
  uart_if.slave   bus,
  input  logic    uart_rx,
  output logic    uart_tx
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t          tx_state_q, tx_state_d;
  logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
  logic [2:0]      tx_bit_q, tx_bit_d;
  logic [7:0]      tx_shift_q, tx_shift_d;
  logic            tx_q, tx_d;
  logic            tx_busy_q, tx_busy_d;

  logic [2:0]      rx_sync_q, rx_sync_d;
  state_t          rx_state_q, rx_state_d;
  logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            overrun_q, overrun_d;
  logic            frame_err_q, frame_err_d;
  logic            irq_en_q, irq_en_d;
  logic            irq_q, irq_d;

  logic            acc, wr_data, rd_data, wr_stat;
  logic            rx_line, rx_done;
  logic [7:0]      status;

  assign acc     = bus.cs & bus.cpu_strobe;
  assign wr_data = acc & ~bus.rw & ~bus.addr;
  assign rd_data = acc &  bus.rw & ~bus.addr;
  assign wr_stat = acc & ~bus.rw &  bus.addr;
  // rx_sync_q[1] is the synchronized line, rx_sync_q[2] its previous value
  assign rx_line = rx_sync_q[1];

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
    tx_busy_d  = tx_busy_q;
    if (tx_state_q != S_IDLE && tx_cnt_q != '0) begin
      tx_cnt_d = tx_cnt_q - 1'b1;
    end else begin
      case (tx_state_q)
        S_IDLE: if (wr_data) begin
          tx_state_d = S_START;
          tx_cnt_d   = DIV_M1;
          tx_shift_d = bus.data_in;
          tx_d       = 1'b0;
          tx_busy_d  = 1'b1;
        end
        S_START: begin
          tx_state_d = S_DATA;
          tx_cnt_d   = DIV_M1;
          tx_bit_d   = 3'd0;
          tx_d       = tx_shift_q[0];
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
        end
        S_DATA: begin
          tx_cnt_d = DIV_M1;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = S_STOP;
            tx_d       = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_d       = tx_shift_q[0];
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
          end
        end
        default: begin
          tx_state_d = S_IDLE;
          tx_busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    rx_sync_d  = {rx_sync_q[1:0], uart_rx};
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_done    = 1'b0;
    if (rx_state_q != S_IDLE && rx_cnt_q != '0) begin
      rx_cnt_d = rx_cnt_q - 1'b1;
    end else begin
      case (rx_state_q)
        S_IDLE: if (rx_sync_q[2] && !rx_line) begin
          rx_state_d = S_START;
          rx_cnt_d   = HALF_M1;
        end
        S_START: begin
          rx_state_d = rx_line ? S_IDLE : S_DATA;
          rx_cnt_d   = DIV_M1;
          rx_bit_d   = 3'd0;
        end
        S_DATA: begin
          rx_cnt_d   = DIV_M1;
          rx_shift_d = {rx_line, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end
        default: begin
          rx_state_d = S_IDLE;
          rx_done    = 1'b1;
        end
      endcase
    end
  end

  // Register file: a completing byte takes priority over reads and clears
  always_comb begin
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    overrun_d   = overrun_q;
    frame_err_d = frame_err_q;
    irq_en_d    = irq_en_q;
    if (rx_done) begin
      rx_data_d  = rx_shift_q;
      rx_valid_d = 1'b1;
    end else if (rd_data) begin
      rx_valid_d = 1'b0;
    end
    if (rx_done && rx_valid_q && !rd_data) overrun_d = 1'b1;
    else if (wr_stat && bus.data_in[2])    overrun_d = 1'b0;
    if (rx_done && !rx_line)               frame_err_d = 1'b1;
    else if (wr_stat && bus.data_in[3])    frame_err_d = 1'b0;
    if (wr_stat && bus.data_in[7])         irq_en_d = 1'b1;
    irq_d = irq_en_q & rx_valid_q;
  end

  always_ff @(posedge clk) begin
    tx_shift_q <= tx_shift_d;
    rx_shift_q <= rx_shift_d;
    if (rst) begin
      tx_state_q  <= S_IDLE;
      tx_cnt_q    <= '0;
      tx_bit_q    <= 3'd0;
      tx_q        <= 1'b1;
      tx_busy_q   <= 1'b0;
      rx_sync_q   <= 3'b111;
      rx_state_q  <= S_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= 3'd0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      irq_en_q    <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_q        <= tx_d;
      tx_busy_q   <= tx_busy_d;
      rx_sync_q   <= rx_sync_d;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      irq_en_q    <= irq_en_d;
      irq_q       <= irq_d;
    end
  end

  assign status = {irq_en_q, 3'b000, frame_err_q, overrun_q, rx_valid_q, tx_busy_q};

  always_comb begin
    bus.data_out = 8'h00;
    if (bus.cs) bus.data_out = bus.addr ? status : rx_data_q;
  end

  assign bus.irq = irq_q;
  assign uart_tx = tx_q;

endmodule

// File: tb/tb_uart.sv
// Randomized bench for uart at DIV = 8, compared against a register-level
// model of the UART status rules and an ideal serial frame.
module tb_uart;
  localparam int DIV = 8;

  logic clk = 1'b0;
  logic rst;
  logic uart_rx;
  logic uart_tx;
  int   n_chk  = 0;
  int   n_pass = 0;

  uart_if u_if();

  uart #(.CLK_HZ(921_600), .BAUD(115_200)) dut (
    .clk(clk), .rst(rst), .bus(u_if), .uart_rx(uart_rx), .uart_tx(uart_tx)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [7:0] m_data;
  logic       m_rv, m_ov, m_fe, m_ie;

  function automatic logic [7:0] m_status();
    return {m_ie, 3'b000, m_fe, m_ov, m_rv, 1'b0};
  endfunction

  task automatic m_reset();
    m_data = 8'h00; m_rv = 1'b0; m_ov = 1'b0; m_fe = 1'b0; m_ie = 1'b0;
  endtask

  task automatic m_byte(input logic [7:0] b, input logic stopb);
    if (m_rv) m_ov = 1'b1;
    m_rv   = 1'b1;
    m_data = b;
    if (!stopb) m_fe = 1'b1;
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic bus_idle();
    u_if.cs = 1'b0; u_if.cpu_strobe = 1'b0; u_if.rw = 1'b1;
    u_if.addr = 1'b0; u_if.data_in = 8'h00;
  endtask

  task automatic bus_write(input logic a, input logic [7:0] d);
    u_if.cs = 1'b1; u_if.cpu_strobe = 1'b1; u_if.rw = 1'b0;
    u_if.addr = a; u_if.data_in = d;
    tick();
    bus_idle();
    if (a) begin
      if (d[7]) m_ie = 1'b1;
      if (d[2]) m_ov = 1'b0;
      if (d[3]) m_fe = 1'b0;
    end
  endtask

  task automatic bus_read(input logic a, output logic [7:0] d);
    u_if.cs = 1'b1; u_if.cpu_strobe = 1'b1; u_if.rw = 1'b1; u_if.addr = a;
    #1 d = u_if.data_out;
    @(posedge clk); #1;
    bus_idle();
    if (!a) m_rv = 1'b0;
  endtask

  task automatic peek(input logic a, output logic [7:0] d);
    u_if.cs = 1'b1; u_if.cpu_strobe = 1'b0; u_if.addr = a;
    #1 d = u_if.data_out;
    u_if.cs = 1'b0;
  endtask

  // Transmit one byte and check every cycle of the frame against the ideal waveform
  task automatic tx_send(input logic [7:0] b, input logic second);
    logic [9:0] frame;
    logic [7:0] st;
    int         lows;
    frame = {1'b1, b, 1'b0};
    bus_write(1'b0, b);
    for (int k = 0; k < 10 * DIV; k++) begin
      chk("tx_line", {7'd0, uart_tx}, {7'd0, frame[k / DIV]});
      if (k == 40 || k == 10 * DIV - 1) begin
        peek(1'b1, st);
        chk("tx_busy_on", {7'd0, st[0]}, 8'h01);
      end
      if (second && k == 20) begin
        u_if.cs = 1'b1; u_if.cpu_strobe = 1'b1; u_if.rw = 1'b0;
        u_if.addr = 1'b0; u_if.data_in = ~b;
        tick();
        bus_idle();
      end else begin
        tick();
      end
    end
    peek(1'b1, st);
    chk("tx_busy_off", {7'd0, st[0]}, 8'h00);
    lows = 0;
    for (int k = 0; k < 3 * DIV; k++) begin
      if (uart_tx !== 1'b1) lows++;
      tick();
    end
    chk("tx_idle_after", 8'(lows), 8'h00);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stopb);
    uart_rx = 1'b0;
    repeat (DIV) tick();
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (DIV) tick();
    end
    uart_rx = stopb;
    repeat (DIV) tick();
    uart_rx = 1'b1;
    m_byte(b, stopb);
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] b;
    logic       sb;
    bus_idle();
    uart_rx = 1'b1;
    rst = 1'b1;
    m_reset();
    repeat (3) begin
      tick();
      chk("rst_tx", {7'd0, uart_tx}, 8'h01);
      chk("rst_irq", {7'd0, u_if.irq}, 8'h00);
    end
    rst = 1'b0;
    tick();
    peek(1'b1, d);
    chk("rst_status", d, 8'h00);

    tx_send(8'hA5, 1'b1);
    repeat (3) tx_send(8'($urandom), 1'b0);

    bus_write(1'b1, 8'h80);
    send_rx(8'h3C, 1'b1);
    repeat (3) tick();
    peek(1'b1, d);
    chk("rx_status", d, m_status());
    chk("rx_irq", {7'd0, u_if.irq}, 8'h01);
    bus_read(1'b0, d);
    chk("rx_data", d, 8'h3C);
    tick();
    chk("irq_drop", {7'd0, u_if.irq}, 8'h00);
    peek(1'b1, d);
    chk("status_after_rd", d, 8'h80);

    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    repeat (3) tick();
    peek(1'b0, d);
    chk("ovr_data", d, 8'h22);
    peek(1'b1, d);
    chk("ovr_status", d, m_status());
    chk("ovr_bit", {7'd0, d[2]}, 8'h01);
    u_if.addr = 1'b0; u_if.cs = 1'b0;
    #1 chk("dout_nocs", u_if.data_out, 8'h00);
    bus_write(1'b1, 8'h04);
    peek(1'b1, d);
    chk("ovr_clear", d, m_status());
    bus_read(1'b0, d);
    chk("ovr_rd", d, m_data);

    send_rx(8'h55, 1'b0);
    repeat (3) tick();
    peek(1'b0, d);
    chk("fe_data", d, 8'h55);
    peek(1'b1, d);
    chk("fe_status", d, m_status());
    bus_read(1'b0, d);
    bus_write(1'b1, 8'h08);
    uart_rx = 1'b0;
    repeat (2) tick();
    uart_rx = 1'b1;
    repeat (30) tick();
    peek(1'b1, d);
    chk("glitch_status", d, m_status());

    for (int n = 0; n < 6; n++) begin
      b  = 8'($urandom);
      sb = ($urandom_range(0, 3) != 0);
      send_rx(b, sb);
      repeat (3) tick();
      peek(1'b1, d);
      chk("rnd_status", d, m_status());
      chk("rnd_irq", {7'd0, u_if.irq}, {7'd0, m_ie & m_rv});
      if ($urandom_range(0, 1) == 1) begin
        bus_read(1'b0, d);
        chk("rnd_data", d, m_data);
      end
      if ($urandom_range(0, 1) == 1) bus_write(1'b1, {1'b1, 3'b000, 2'($urandom), 2'b00});
      repeat (2) tick();
      peek(1'b1, d);
      chk("rnd_status2", d, m_status());
    end

    bus_write(1'b0, 8'($urandom));
    repeat (30) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_reset();
    chk("midrst_tx", {7'd0, uart_tx}, 8'h01);
    peek(1'b1, d);
    chk("midrst_status", d, 8'h00);
    tx_send(8'h0F, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
